// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, fetches over a req/gnt/rvalid
// handshake and holds the fetched word until the core commits it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        advance,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] retired
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t state;
  state_t state_next;
  logic   commit_c;
  logic   capture_c;

  // Next-state decode; commit and capture strobes steer the datapath registers.
  always_comb begin
    state_next = state;
    commit_c   = 1'b0;
    capture_c  = 1'b0;
    case (state)
      S_BOOT: state_next = S_REQ;
      S_REQ:  if (imem_gnt) state_next = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          capture_c  = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (advance && !stall) begin
          commit_c   = 1'b1;
          state_next = (next_pc[1:0] == 2'b00) ? S_REQ : S_ERR;
        end
      end
      S_ERR:   state_next = S_ERR;
      default: state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_next;
  end

  // imem_req is registered from the upcoming state so it tracks S_REQ exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      imem_req  <= (state_next == S_REQ);
      fetch_err <= fetch_err | (state_next == S_ERR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (capture_c) begin
      instr       <= imem_rdata;
      instr_valid <= 1'b1;
    end else if (commit_c) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end
  end

  // PC and retire counter move only on a commit; a misaligned target is kept for debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      retired <= '0;
    end else if (commit_c) begin
      pc      <= next_pc;
      retired <= retired + XLEN'(1);
    end
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected requests and fetched words into
// queues that a separate monitor pops whenever the DUT raises imem_req or instr_valid.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_pc = '0;
  logic        advance = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic [31:0] retired;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] retired;
  } fetch_exp_t;

  logic [31:0] req_q[$];
  fetch_exp_t  fetch_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_pc    (next_pc),
    .advance    (advance),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: samples just after each rising edge, independent of the stimulus thread.
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] cur_addr = '0;
  always @(posedge clk) begin
    #1;
    if (imem_req && !prev_req) begin
      if (req_q.size() == 0) fail_now("unexpected_req");
      else begin
        cur_addr = req_q.pop_front();
        check("req_addr", imem_addr, cur_addr);
      end
    end else if (imem_req) begin
      check("req_addr_stable", imem_addr, cur_addr);
    end
    if (instr_valid && !prev_valid) begin
      if (fetch_q.size() == 0) fail_now("unexpected_instr_valid");
      else begin
        fetch_exp_t e;
        e = fetch_q.pop_front();
        check("fetch_pc", pc, e.pc);
        check("fetch_instr", instr, e.instr);
        check("fetch_retired", retired, e.retired);
      end
    end
    prev_req   = imem_req;
    prev_valid = instr_valid;
  end

  // Memory side of one fetch; caller sits at a falling edge. Optional rvalid pulse while in S_REQ.
  task automatic fetch(input int gd, input int rd, input logic [31:0] data, input logic pulse);
    int waited = 0;
    while (!imem_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!imem_req) begin
      fail_now("req_timeout");
      return;
    end
    for (int i = 0; i < gd; i++) begin
      imem_rvalid = pulse && (i == 0);
      imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_rvalid = 1'b0;
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    repeat (rd) @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  task automatic commit(input logic [31:0] npc);
    advance = 1'b1;
    next_pc = npc;
    @(negedge clk);
    advance = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_pc"}, pc, 32'h0000_3000);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_err"}, 32'(fetch_err), 32'd0);
    check({tag, "_retired"}, retired, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then first fetch with earliest gnt/rvalid.
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    req_q.push_back(32'h0000_3000);
    fetch_q.push_back('{32'h0000_3000, 32'h2401_0005, 32'h0});
    rst_n = 1'b1;
    fetch(0, 0, 32'h2401_0005, 1'b0);

    // Stall blocks commit; values hold.
    advance = 1'b1;
    stall   = 1'b1;
    next_pc = 32'h0000_3004;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_pc", pc, 32'h0000_3000);
      check("stall_instr", instr, 32'h2401_0005);
      check("stall_valid", 32'(instr_valid), 32'd1);
    end
    req_q.push_back(32'h0000_3004);
    fetch_q.push_back('{32'h0000_3004, 32'h0000_0013, 32'd1});
    stall = 1'b0;
    @(negedge clk);
    advance = 1'b0;
    check("commit_pc", pc, 32'h0000_3004);
    check("commit_retired", retired, 32'd1);
    check("commit_valid", 32'(instr_valid), 32'd0);
    check("commit_instr", instr, 32'h0);
    check("commit_req", 32'(imem_req), 32'd1);

    // Delayed gnt and rvalid, with a stray rvalid during S_REQ.
    fetch(3, 5, 32'h0000_0013, 1'b1);
    check("delayed_instr", instr, 32'h0000_0013);

    // Retire counter wrap.
    force dut.retired = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retired;
    check("preload_retired", retired, 32'hFFFF_FFFF);
    req_q.push_back(32'h0000_3008);
    fetch_q.push_back('{32'h0000_3008, 32'h0010_0093, 32'h0});
    commit(32'h0000_3008);
    check("wrap_retired", retired, 32'h0);
    check("wrap_pc", pc, 32'h0000_3008);
    check("wrap_err", 32'(fetch_err), 32'd0);
    fetch(1, 1, 32'h0010_0093, 1'b0);

    // Misaligned target: sticky error, no further activity.
    commit(32'h0000_3002);
    for (int i = 0; i < 3; i++) begin
      check("err_flag", 32'(fetch_err), 32'd1);
      check("err_valid", 32'(instr_valid), 32'd0);
      check("err_req", 32'(imem_req), 32'd0);
      check("err_pc", pc, 32'h0000_3002);
      check("err_instr", instr, 32'h0);
      check("err_retired", retired, 32'd1);
      advance     = 1'b1;
      next_pc     = 32'h0000_4000;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
      @(negedge clk);
    end
    advance     = 1'b0;
    imem_rvalid = 1'b0;

    // Reset out of S_ERR, then asynchronous reset while in S_WAIT.
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("err_reset");
    req_q.push_back(32'h0000_3000);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_req", 32'(imem_req), 32'd1);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    req_q.push_back(32'h0000_3000);
    fetch_q.push_back('{32'h0000_3000, 32'h2401_0005, 32'h0});
    rst_n = 1'b1;
    fetch(0, 1, 32'h2401_0005, 1'b0);

    repeat (3) @(negedge clk);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage holding the architectural PC register.
- Issues requests to instruction memory over a req/gnt/rvalid handshake and presents the fetched instruction and its PC to the downstream next-PC and decode logic.
- Loads the next-PC value only when the core commits the current instruction, so the single-cycle datapath tolerates multi-cycle instruction memory.

Parameters:
RESET_PC, 32'h00003000, PC value loaded on reset (word aligned)
NOP_INSTR, 32'h00000000, value driven on instr whenever instr_valid=0 or in error state

Ports:
clk  in  1  clock; all state changes on its rising edge
rst_n  in  1  asynchronous active-low reset
next_pc  in  32  next PC computed downstream from pc/instr
advance  in  1  core commits the current instruction this cycle
stall  in  1  core hold; blocks advance
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, equals pc
imem_gnt  in  1  memory accepted the request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  read data
pc  out  32  PC of the instruction on instr
instr  out  32  fetched instruction
instr_valid  out  1  instr holds the valid word for pc
fetch_err  out  1  sticky misaligned-target flag
retired  out  32  count of committed instructions

Behaviour:
- Reset (rst_n=0, asynchronous) forces the following values:
  - state=S_BOOT, pc=RESET_PC, instr=NOP_INSTR
  - instr_valid=0, imem_req=0, fetch_err=0, retired=0
- Outputs are decoded from registered state only. There are no combinational paths from inputs to outputs, except imem_addr, which is the pc register.
- States:
  - S_BOOT: imem_req=0. Go to S_REQ next cycle unconditionally.
  - S_REQ: imem_req=1, imem_addr=pc. If imem_gnt=1, go to S_WAIT; otherwise stay, holding req and addr stable.
  - S_WAIT: imem_req=0. Any imem_rvalid seen in the gnt cycle is ignored; data is accepted from the cycle after gnt. On imem_rvalid=1, instr<=imem_rdata, instr_valid<=1, go to S_HOLD. Otherwise wait indefinitely.
  - S_HOLD: instr_valid=1, and pc/instr are held stable. On commit (advance=1 and stall=0):
    - pc<=next_pc, retired<=retired+1 (wraps modulo 2^32).
    - instr_valid<=0, instr<=NOP_INSTR.
    - If next_pc[1:0]==0, go to S_REQ; otherwise go to S_ERR.
  - S_ERR: fetch_err=1 (sticky), imem_req=0, instr_valid=0, instr=NOP_INSTR. pc holds the misaligned target for debug. The block leaves this state only on reset.
- advance is ignored outside S_HOLD. stall=1 always suppresses commit.
- imem_rvalid outside S_WAIT is ignored; no data is captured.
- Minimum fetch latency is 3 cycles from entry to S_REQ to instr_valid=1: S_REQ with gnt → S_WAIT with rvalid → S_HOLD.
- Back-to-back throughput is one instruction per 3 cycles when gnt and rvalid arrive at the earliest allowed cycle.
- Reset mid-transaction (S_REQ or S_WAIT) abandons the fetch. The memory is reset by the same rst_n, so no stale response is expected.
- next_pc is sampled only on the commit edge, and all 32 bits are loaded unchanged.

Test Plan:
- Reset release, gnt and rvalid at earliest cycles, imem_rdata=32'h24010005 → imem_req=1 with imem_addr=32'h00003000 in the 2nd cycle after release; instr_valid=1 with instr=32'h24010005, pc=32'h00003000 two cycles later.
- In S_HOLD, advance=1, stall=1 for 4 cycles, then stall=0 with next_pc=32'h00003004 → pc, instr and instr_valid hold during the stall; on release pc=32'h00003004, retired=1, a new request is issued, and instr_valid=0 in between.
- gnt delayed 3 cycles and rvalid delayed 5 cycles, with rvalid also pulsed during S_REQ → imem_req/imem_addr stay stable until gnt; the early rvalid is not captured; data is captured only in S_WAIT.
- Commit with next_pc=32'h00003002 → fetch_err=1, instr_valid=0, imem_req=0, pc=32'h00003002. Further advance and rvalid have no effect until rst_n=0.
- Assert rst_n=0 asynchronously while in S_WAIT → all outputs immediately take their reset values. After release the fetch restarts at RESET_PC with retired=0.
- Preload retired near wrap (32'hFFFFFFFF) by running, or via a forced value in the bench, then commit one instruction → retired=32'h00000000 and no other effect.
